// File: rtl/edge_detector_frame_ctrl.sv
// Frame-level sequencer for the edge-detection filter: walks every pixel of an
// IMG_W x IMG_H frame through get -> calc -> put, with abort and a done pulse.
module edge_detector_frame_ctrl #(
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int CALC_CYCLES = 4,
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int CW = $clog2(CALC_CYCLES + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          calc_en_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [2:0]    state_dbg_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here are pure functions of the registered state,
    // and abort_i overrides any transfer on the same edge.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_GET  = 3'd2,
        ST_CALC = 3'd3,
        ST_PUT  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CALC_CYCLES - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, calc_en_q, out_valid_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                x_d = '0;
                y_d = '0;
                if (!start_i) state_d = ST_GET;
            end
            ST_GET: begin
                if (in_valid_i) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = ST_PUT;
                    cnt_d   = '0;
                end
            end
            ST_PUT: begin
                if (out_ready_i) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GET;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                y_d     = '0;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every transition, including a same-cycle handshake.
        if (abort_i && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            calc_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_GET);
            calc_en_q   <= (state_d == ST_CALC);
            out_valid_q <= (state_d == ST_PUT);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign calc_en_o   = calc_en_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pix_x_o     = x_q;
    assign pix_y_o     = y_q;
    assign state_dbg_o = state_q;

endmodule
